hex_word_printer: RTL and testbench

- Upstream feeder for the nibble-to-ASCII converter in the gfx text path.
- Accepts one binary word per handshake and serialises it MSB-nibble-first as a stream of ASCII characters, with an optional "0x" prefix and a trailing separator.
- Drives the converter's nibble input and consumes its ASCII output combinationally.
- Feeds the character writer of the text overlay through a valid/ready character stream.

---
 rtl/hex_word_printer.sv | 100 ++++++++++
 tb/tb_hex_word_printer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_printer.sv
// Serialises one binary word per handshake into an ASCII hex character stream:
// optional "0x" prefix, MSB-nibble-first digits via an external converter, optional separator.
module hex_word_printer #(
  parameter int         WORD_WIDTH = 32,
  parameter bit         PREFIX_EN  = 1'b1,
  parameter bit         SEP_EN     = 1'b1,
  parameter logic [7:0] SEP_CHAR   = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic [3:0]            nibble,
  input  logic [7:0]            ascii,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic [7:0]            char_data,
  output logic                  busy
);

  localparam int            NDIG     = WORD_WIDTH / 4;
  localparam int            CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, SEP} state_t;

  state_t                r_state, w_state_nxt;
  logic [WORD_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]         r_cnt,   w_cnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    word_ready  = 1'b0;
    char_valid  = 1'b1;
    char_data   = 8'h00;
    unique case (r_state)
      IDLE: begin
        word_ready = 1'b1;
        char_valid = 1'b0;
        if (word_valid) begin
          w_shift_nxt = word_data;
          w_cnt_nxt   = LAST_DIG;
          if (PREFIX_EN) w_state_nxt = PFX0;
          else           w_state_nxt = DIGIT;
        end
      end
      PFX0: begin
        char_data = 8'h30;
        if (char_ready) w_state_nxt = PFX1;
      end
      PFX1: begin
        char_data = 8'h78;
        if (char_ready) w_state_nxt = DIGIT;
      end
      DIGIT: begin
        char_data = ascii;
        if (char_ready) begin
          if (r_cnt != '0) begin
            w_shift_nxt = r_shift << 4;
            w_cnt_nxt   = r_cnt - 1'b1;
          end else if (SEP_EN) begin
            w_state_nxt = SEP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      SEP: begin
        char_data = SEP_CHAR;
        if (char_ready) w_state_nxt = IDLE;
      end
      default: begin
        char_valid  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Converter input comes straight from the register, so nothing upstream can glitch it.
  assign nibble = r_shift[WORD_WIDTH-1 -: 4];
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_hex_word_printer.sv
// Self-checking bench for hex_word_printer: three configurations driven with directed
// and randomized words, character streams compared against a string-level model.
module tb_hex_word_printer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wv  [3];
  logic        wr  [3];
  logic [31:0] wd  [3];
  logic [3:0]  nib [3];
  logic [7:0]  asc [3];
  logic        cv  [3];
  logic        cr  [3];
  logic [7:0]  cd  [3];
  logic        bsy [3];

  int    n_cmp = 0;
  int    n_err = 0;
  string got_s;
  int    acc_cyc[$];
  int    chr_cyc[$];
  int    end_cyc;
  int    stall_bad;
  bit    timeout;

  // Behavioural nibble-to-ASCII converter (lowercase).
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h61 + 8'(n) - 8'd10);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_conv
    assign asc[k] = hex_char(nib[k]);
  end

  hex_word_printer u_def (
    .clk(clk), .rst(rst), .word_valid(wv[0]), .word_ready(wr[0]), .word_data(wd[0]),
    .nibble(nib[0]), .ascii(asc[0]), .char_valid(cv[0]), .char_ready(cr[0]),
    .char_data(cd[0]), .busy(bsy[0]));

  hex_word_printer #(.PREFIX_EN(1'b0), .SEP_EN(1'b0)) u_bare (
    .clk(clk), .rst(rst), .word_valid(wv[1]), .word_ready(wr[1]), .word_data(wd[1]),
    .nibble(nib[1]), .ascii(asc[1]), .char_valid(cv[1]), .char_ready(cr[1]),
    .char_data(cd[1]), .busy(bsy[1]));

  hex_word_printer #(.WORD_WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .word_valid(wv[2]), .word_ready(wr[2]), .word_data(wd[2][7:0]),
    .nibble(nib[2]), .ascii(asc[2]), .char_valid(cv[2]), .char_ready(cr[2]),
    .char_data(cd[2]), .busy(bsy[2]));

  // Reference model: the text a word should print as, for instance k's configuration.
  function automatic string expect_str(input int k, input logic [31:0] w);
    string s;
    s = (k == 1) ? "" : "0x";
    if (k == 2) s = {s, $sformatf("%h", w[7:0])};
    else        s = {s, $sformatf("%h", w)};
    if (k != 1) s = {s, " "};
    return s;
  endfunction

  // Offers the queued words back-to-back on instance k and records every transfer.
  // rmode: 0 = char_ready high, 1 = random, 2 = toggling. abort_n > 0 stops after that many chars.
  task automatic run_words(input int k, input logic [31:0] words[$], input int rmode,
                           input int abort_n);
    int       idx = 0;
    bit       held = 1'b0;
    bit       done = 1'b0;
    bit       acc_now;
    logic [7:0] held_c = 8'h00;
    got_s = "";
    acc_cyc.delete();
    chr_cyc.delete();
    stall_bad = 0;
    end_cyc = -1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      wv[k] = (idx < words.size());
      if (idx < words.size()) wd[k] = words[idx];
      case (rmode)
        0:       cr[k] = 1'b1;
        1:       cr[k] = 1'($urandom_range(0, 1));
        default: cr[k] = ((cyc % 2) == 1);
      endcase
      @(negedge clk);
      acc_now = wv[k] && wr[k];
      if (acc_now) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (held && cv[k] && (cd[k] !== held_c)) stall_bad++;
      held   = cv[k] && !cr[k];
      held_c = cd[k];
      if (cv[k] && cr[k]) begin
        got_s = $sformatf("%s%c", got_s, cd[k]);
        chr_cyc.push_back(cyc);
      end
      if (abort_n > 0 && chr_cyc.size() == abort_n) begin
        done = 1'b1;
        break;
      end
      if (idx == words.size() && !acc_now && !bsy[k]) begin
        end_cyc = cyc;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    timeout = !done;
    @(posedge clk); #1;
    wv[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wv[k] = 1'b0; wd[k] = '0; cr[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (wr[k] !== 1'b1)   begin n_err++; $display("FAIL reset_word_ready[%0d]: got %b want 1", k, wr[k]); end
      n_cmp++; if (cv[k] !== 1'b0)   begin n_err++; $display("FAIL reset_char_valid[%0d]: got %b want 0", k, cv[k]); end
      n_cmp++; if (bsy[k] !== 1'b0)  begin n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", k, bsy[k]); end
      n_cmp++; if (nib[k] !== 4'h0)  begin n_err++; $display("FAIL reset_nibble[%0d]: got %h want 0", k, nib[k]); end
      n_cmp++; if (cd[k] !== 8'h00)  begin n_err++; $display("FAIL reset_char_data[%0d]: got %h want 00", k, cd[k]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_deadbeef();
    logic [31:0] q[$];
    string exp_s;
    q.push_back(32'hDEADBEEF);
    exp_s = expect_str(0, 32'hDEADBEEF);
    run_words(0, q, 0, 0);
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL deadbeef_timeout: got timeout want completion"); end
    n_cmp++; if (got_s != exp_s) begin n_err++; $display("FAIL deadbeef_stream: got \"%s\" want \"%s\"", got_s, exp_s); end
    if (acc_cyc.size() > 0 && chr_cyc.size() > 0) begin
      n_cmp++; if (chr_cyc[0] - acc_cyc[0] !== 1) begin n_err++; $display("FAIL deadbeef_first_latency: got %0d want 1", chr_cyc[0] - acc_cyc[0]); end
      n_cmp++; if (chr_cyc[$] - acc_cyc[0] !== 11) begin n_err++; $display("FAIL deadbeef_last_char_cycle: got %0d want 11", chr_cyc[$] - acc_cyc[0]); end
      n_cmp++; if (end_cyc - acc_cyc[0] !== 12) begin n_err++; $display("FAIL deadbeef_idle_cycle: got %0d want 12", end_cyc - acc_cyc[0]); end
    end else begin
      n_cmp++; n_err++; $display("FAIL deadbeef_activity: got accepts=%0d chars=%0d want nonzero", acc_cyc.size(), chr_cyc.size());
    end
    n_cmp++; if (wr[0] !== 1'b1) begin n_err++; $display("FAIL deadbeef_word_ready_after: got %b want 1", wr[0]); end
  endtask

  task automatic test_no_prefix();
    logic [31:0] q[$];
    q.push_back(32'h0000000A);
    run_words(1, q, 0, 0);
    n_cmp++; if (got_s != "0000000a") begin n_err++; $display("FAIL bare_stream: got \"%s\" want \"0000000a\"", got_s); end
    n_cmp++; if (acc_cyc.size() == 0 || end_cyc - acc_cyc[0] !== 9) begin n_err++; $display("FAIL bare_idle_cycle: got %0d want 9", end_cyc); end
    n_cmp++; if (bsy[1] !== 1'b0) begin n_err++; $display("FAIL bare_busy_after: got %b want 0", bsy[1]); end
  endtask

  task automatic test_stall(input int rmode, input logic [31:0] w);
    logic [31:0] q[$];
    string exp_s;
    q.push_back(w);
    exp_s = expect_str(0, w);
    run_words(0, q, rmode, 0);
    n_cmp++; if (got_s != exp_s) begin n_err++; $display("FAIL stall_stream(mode %0d): got \"%s\" want \"%s\"", rmode, got_s, exp_s); end
    n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL stall_hold(mode %0d): got %0d unstable cycles want 0", rmode, stall_bad); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    q.push_back(32'h1);
    q.push_back(32'hF);
    run_words(0, q, 0, 0);
    n_cmp++; if (got_s != "0x00000001 0x0000000f ") begin n_err++; $display("FAIL b2b_stream: got \"%s\" want \"0x00000001 0x0000000f \"", got_s); end
    n_cmp++;
    if (acc_cyc.size() !== 2) begin
      n_err++; $display("FAIL b2b_accepts: got %0d want 2", acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] !== 12) begin
      n_err++; $display("FAIL b2b_accept_gap: got %0d want 12", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q[$];
    q.push_back(32'hCAFEF00D);
    run_words(0, q, 0, 5);
    rst = 1'b1;
    cr[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (got_s != "0xcaf") begin n_err++; $display("FAIL abort_prefix_stream: got \"%s\" want \"0xcaf\"", got_s); end
    n_cmp++; if (cv[0] !== 1'b0) begin n_err++; $display("FAIL abort_char_valid: got %b want 0", cv[0]); end
    n_cmp++; if (bsy[0] !== 1'b0 || wr[0] !== 1'b1) begin n_err++; $display("FAIL abort_idle: got busy=%b ready=%b want busy=0 ready=1", bsy[0], wr[0]); end
    @(posedge clk); #1;
    q.delete();
    q.push_back(32'h0);
    run_words(0, q, 0, 0);
    n_cmp++; if (got_s != "0x00000000 ") begin n_err++; $display("FAIL abort_recovery_stream: got \"%s\" want \"0x00000000 \"", got_s); end
  endtask

  task automatic test_width8();
    logic [31:0] q[$];
    q.push_back(32'hA5);
    run_words(2, q, 0, 0);
    n_cmp++; if (got_s != "0xa5 ") begin n_err++; $display("FAIL w8_stream: got \"%s\" want \"0xa5 \"", got_s); end
    n_cmp++; if (acc_cyc.size() == 0 || end_cyc - acc_cyc[0] !== 6) begin n_err++; $display("FAIL w8_idle_cycle: got %0d want 6", end_cyc); end
  endtask

  task automatic test_random_words();
    logic [31:0] q[$];
    logic [31:0] w;
    string exp_s;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 3; r++) begin
        q.delete();
        exp_s = "";
        for (int n = 0; n < 3; n++) begin
          w = $urandom;
          q.push_back(w);
          exp_s = {exp_s, expect_str(k, w)};
        end
        run_words(k, q, 1, 0);
        n_cmp++; if (got_s != exp_s) begin n_err++; $display("FAIL rand_stream[%0d.%0d]: got \"%s\" want \"%s\"", k, r, got_s, exp_s); end
        n_cmp++; if (stall_bad !== 0 || timeout !== 1'b0) begin n_err++; $display("FAIL rand_hold[%0d.%0d]: got unstable=%0d timeout=%b want 0/0", k, r, stall_bad, timeout); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_deadbeef();
    test_no_prefix();
    test_stall(1, 32'h12345678);
    test_stall(2, 32'h9ABCDEF0);
    test_back_to_back();
    test_reset_mid();
    test_width8();
    test_random_words();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
